// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO unit with a single-cycle 32x32 multiply and a 32-cycle restoring divider.
// Define MULDIV_MADD_EN to enable the accumulate ops (MADD/MADDU/MSUB/MSUBU); otherwise op[2] is ignored.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    output logic        busy,
    output logic        finish,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_reg, state_next;

    logic [2:0]  op_reg;
    logic [31:0] a_reg, b_reg;
    logic [31:0] rem_reg, quo_reg, den_reg;
    logic [4:0]  count_reg;
    logic [31:0] hi_reg, lo_reg;
`ifdef MULDIV_MADD_EN
    logic [63:0] acc_reg;
`endif

    logic        accept, op_is_div, in_signed, op_signed;
    logic [31:0] mag_a, mag_b;

    assign op_is_div = (op[2:1] == 2'b01);
    assign in_signed = ~op[0];
    assign op_signed = ~op_reg[0];
    assign accept    = (state_reg == IDLE) && start && !flush;
    assign mag_a     = (in_signed && src_a[31]) ? -src_a : src_a;
    assign mag_b     = (in_signed && src_b[31]) ? -src_b : src_b;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = op_is_div ? DIV : MUL;
            MUL:     state_next = DONE;
            DIV:     if (count_reg == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Flush outranks everything, including a start in IDLE.
        if (flush) state_next = IDLE;
    end

    assign busy   = (state_reg == MUL) || (state_reg == DIV) || accept;
    assign finish = (state_reg == DONE);
    assign hi_out = hi_reg;
    assign lo_out = lo_reg;

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    logic [32:0] shifted, diff;
    logic        q_bit;
    logic [31:0] rem_step, quo_step;
    assign shifted  = {rem_reg, quo_reg[31]};
    assign diff     = shifted - {1'b0, den_reg};
    assign q_bit    = ~diff[32];
    assign rem_step = q_bit ? diff[31:0] : shifted[31:0];
    assign quo_step = {quo_reg[30:0], q_bit};

    logic [63:0] div_result;
    always_comb begin
        div_result = {rem_step, quo_step};
        if (b_reg == 32'd0) begin
            div_result = {a_reg, 32'hFFFF_FFFF};
        end else begin
            if (op_signed && a_reg[31])             div_result[63:32] = -rem_step;
            if (op_signed && (a_reg[31] ^ b_reg[31])) div_result[31:0] = -quo_step;
        end
    end

    // Sign- or zero-extend to 64 bits so one multiplier serves both signednesses.
    logic [63:0] mul_a, mul_b, product, mul_result;
    assign mul_a   = {{32{op_signed & a_reg[31]}}, a_reg};
    assign mul_b   = {{32{op_signed & b_reg[31]}}, b_reg};
    assign product = mul_a * mul_b;

`ifdef MULDIV_MADD_EN
    always_comb begin
        mul_result = product;
        if (op_reg[2]) mul_result = op_reg[1] ? (acc_reg - product) : (acc_reg + product);
    end
`else
    logic unused_madd;
    assign mul_result  = product;
    assign unused_madd = ^{hi_in, lo_in, op_reg[2:1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            den_reg   <= '0;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
`ifdef MULDIV_MADD_EN
            acc_reg   <= '0;
`endif
        end else begin
            if (accept) begin
                op_reg    <= op;
                a_reg     <= src_a;
                b_reg     <= src_b;
                rem_reg   <= '0;
                quo_reg   <= mag_a;
                den_reg   <= mag_b;
                count_reg <= '0;
`ifdef MULDIV_MADD_EN
                acc_reg   <= {hi_in, lo_in};
`endif
            end else if (state_reg == DIV) begin
                rem_reg   <= rem_step;
                quo_reg   <= quo_step;
                count_reg <= count_reg + 5'd1;
            end
            // Results land only on the edge into DONE; an aborted op leaves the old values.
            if (!flush) begin
                if (state_reg == MUL) begin
                    {hi_reg, lo_reg} <= mul_result;
                end else if ((state_reg == DIV) && (count_reg == 5'd31)) begin
                    {hi_reg, lo_reg} <= div_result;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against an arithmetic model,
// and hand-written flush / back-to-back / reset sequences.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] src_a = '0, src_b = '0, hi_in = '0, lo_in = '0;
    logic        busy, finish;
    logic [31:0] hi_out, lo_out;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .busy(busy), .finish(finish),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, h, l, exp_hi, exp_lo;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic void add_vec(input logic [2:0] o, input logic [31:0] a, b, h, l, eh, el);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.h = h; v.l = l; v.exp_hi = eh; v.exp_lo = el;
        vecs.push_back(v);
    endfunction

    // Reference: plain 64-bit arithmetic from the instruction semantics.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b, h, l);
        longint sa, sb, q, r;
        longint unsigned prod;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        if (o[2:1] == 2'b01) begin
            if (b == 32'd0)  res = {a, 32'hFFFF_FFFF};
            else if (o[0])   res = {a % b, a / b};
            else begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
        end else begin
            if (o[0]) prod = {32'd0, a} * {32'd0, b};
            else      prod = sa * sb;
            res = prod;
`ifdef MULDIV_MADD_EN
            if (o[2]) res = o[1] ? ({h, l} - prod) : ({h, l} + prod);
`endif
        end
        return res;
    endfunction

    // Issues one op, scrambles inputs after acceptance, and checks latency, result, pulse width and hold.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, h, l,
                          input logic [63:0] exp, input string tag);
        int lat, exp_lat;
        logic [63:0] got;
        lat = 0;
        got = '0;
        exp_lat = (o[2:1] == 2'b01) ? 32 : 1;
        @(posedge clk); #1;
        op = o; src_a = a; src_b = b; hi_in = h; lo_in = l; start = 1'b1;
        #1 check({tag, "_busy_req"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); src_a = $urandom; src_b = $urandom; hi_in = $urandom; lo_in = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (finish) begin
                lat = k;
                got = {hi_out, lo_out};
                check({tag, "_busy_done"}, 64'(busy), 64'd0);
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, got, exp);
        @(posedge clk); #1;
        check({tag, "_one_pulse"}, 64'(finish), 64'd0);
        check({tag, "_hold"}, {hi_out, lo_out}, exp);
        $display("%s op=%b a=%h b=%h hi_in=%h lo_in=%h -> hi=%h lo=%h lat=%0d",
                 tag, o, a, b, h, l, got[63:32], got[31:0], lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfin, fcyc, consec;
        logic prev_fin;
        logic [63:0] fres;
        logic [2:0]  ro;
        logic [31:0] ra, rb, rh, rl;

        add_vec(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        add_vec(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0, 32'h0000_0002, 32'hFFFF_FFFA);
        add_vec(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        add_vec(3'b011, 32'd100,       32'd7,         32'h0, 32'h0, 32'd2,         32'd14);
        add_vec(3'b011, 32'h1234_5678, 32'h0,         32'h0, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
        add_vec(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000);
        add_vec(3'b010, 32'h8000_0005, 32'h0,         32'h0, 32'h0, 32'h8000_0005, 32'hFFFF_FFFF);
`ifdef MULDIV_MADD_EN
        add_vec(3'b101, 32'd1,         32'd1,         32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        add_vec(3'b110, 32'd1,         32'd1,         32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add_vec(3'b100, 32'hFFFF_FFFE, 32'd3,         32'h0, 32'd10, 32'h0, 32'd4);
        add_vec(3'b111, 32'd2,         32'd3,         32'h1, 32'h0, 32'h0, 32'hFFFF_FFFA);
`else
        add_vec(3'b110, 32'hFFFF_FFFE, 32'd3,         32'h55, 32'h66, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        add_vec(3'b101, 32'hFFFF_FFFE, 32'd3,         32'h5, 32'h7, 32'h0000_0002, 32'hFFFF_FFFA);
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_finish", 64'(finish), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi_out, lo_out}, 64'd0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].l,
                   {vecs[i].exp_hi, vecs[i].exp_lo}, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 50);
                default: rb = $urandom;
            endcase
            rh = $urandom;
            rl = $urandom;
            run_op(ro, ra, rb, rh, rl, model(ro, ra, rb, rh, rl), $sformatf("rnd%0d", i));
        end

        // flush and start together: start dropped
        @(posedge clk); #1;
        op = 3'b000; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        #1 check("flush_start_busy", 64'(busy), 64'd0);
        nfin = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0;
            if (finish) nfin++;
        end
        check("flush_start_no_finish", 64'(nfin), 64'd0);
        $display("flush+start same cycle: finishes=%0d", nfin);

        // DIV flushed at N+10, new DIVU started at N+12 -> result at N+45
        @(posedge clk); #1;
        op = 3'b010; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk);
        nfin = 0; fcyc = 0; fres = '0;
        for (int c = 1; c <= 47; c++) begin
            #1;
            start = 1'b0;
            flush = (c == 10);
            if (c == 12) begin
                op = 3'b011; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
            end
            #1;
            if (c == 11) check("flush_idle_busy", 64'(busy), 64'd0);
            if (c == 12) check("flush_restart_busy", 64'(busy), 64'd1);
            if (finish) begin
                nfin++;
                fcyc = c;
                fres = {hi_out, lo_out};
            end
            @(posedge clk);
        end
        #1 start = 1'b0; flush = 1'b0;
        check("flush_finish_count", 64'(nfin), 64'd1);
        check("flush_finish_cycle", 64'(fcyc), 64'd45);
        check("flush_restart_result", fres, {32'd2, 32'd14});
        $display("flush sequence: finishes=%0d at N+%0d hi=%h lo=%h", nfin, fcyc, fres[63:32], fres[31:0]);

        // start held high: MULT accepted every third cycle, operand tracks the cycle index
        @(posedge clk);
        nfin = 0; consec = 0; prev_fin = 1'b0;
        for (int c = 0; c < 36; c++) begin
            #1;
            start = (c < 30); op = 3'b000; src_a = 32'(c + 1); src_b = 32'd5;
            #1;
            if (finish) begin
                nfin++;
                if (prev_fin) consec++;
                check($sformatf("b2b_result_c%0d", c), {hi_out, lo_out}, 64'((c - 1) * 5));
                check($sformatf("b2b_busy_c%0d", c), 64'(busy), 64'd0);
            end
            prev_fin = finish;
            @(posedge clk);
        end
        #1 start = 1'b0;
        check("b2b_finish_count", 64'(nfin), 64'd10);
        check("b2b_no_adjacent_pulses", 64'(consec), 64'd0);
        $display("back-to-back: finishes=%0d", nfin);

        // reset at N+5 of a DIV
        @(posedge clk); #1;
        op = 3'b010; src_a = 32'd77777; src_b = 32'd3; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            #1;
            start = 1'b0;
            if (c == 5) rst = 1'b1;
            @(posedge clk);
        end
        #1 rst = 1'b0;
        #1;
        check("rst_mid_finish", 64'(finish), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
        nfin = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (finish) nfin++;
        end
        check("rst_mid_no_finish", 64'(nfin), 64'd0);
        $display("reset mid-DIV: finishes=%0d hi=%h lo=%h", nfin, hi_out, lo_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have the port start, input, 1 bit: request an operation; it is sampled only in IDLE.
REQ-004 The module SHALL have the port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-005 The module SHALL have the ports src_a and src_b, input, 32 bits each: rs/rt operands; src_a is the dividend, src_b the divisor.
REQ-006 The module SHALL have the ports hi_in and lo_in, input, 32 bits each: current HI/LO (bypassed) values used by the accumulate operations.
REQ-007 The module SHALL have the port flush, input, 1 bit: abort any in-flight operation (exception/branch flush).
REQ-008 The module SHALL have the port busy, output, 1 bit: stall request to the EXE stage.
REQ-009 The module SHALL have the port finish, output, 1 bit: a one-cycle result-valid pulse; it feeds the HI/LO write enable.
REQ-010 The module SHALL have the ports hi_out and lo_out, output, 32 bits each: final HI/LO result, valid only while finish=1.

Function
REQ-011 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
- IDLE→MUL on start with op≠01x.
- IDLE→DIV on start with op=01x.
- MUL→DONE after 1 cycle.
- DIV→DONE after exactly 32 iteration cycles.
- DONE→IDLE unconditionally.
REQ-012 On acceptance, the unit SHALL capture op, src_a, src_b, hi_in and lo_in into internal registers; later input changes SHALL NOT affect the result.
REQ-013 Multiply latency SHALL be: start accepted at edge N, finish=1 during cycle N+2.
REQ-014 Divide latency SHALL be: start accepted at edge N, finish=1 during cycle N+33.
REQ-015 finish SHALL be 1 only in DONE, exactly one cycle per accepted operation.
REQ-016 busy SHALL equal (state∈{MUL,DIV}) OR (state==IDLE AND start AND !flush); busy SHALL be 0 in DONE so EXE advances with the result.
REQ-017 start while not in IDLE SHALL be ignored.
REQ-018 start in DONE SHALL NOT be accepted; it is accepted in the following IDLE cycle.
REQ-019 MULT/MADD/MSUB SHALL use a signed 32x32→64 product; the U variants SHALL use an unsigned product.
REQ-020 Output mapping SHALL be {hi_out,lo_out} = product.
REQ-021 MADD/MADDU SHALL compute {hi_out,lo_out} = {hi_in,lo_in} + product, modulo 2^64.
REQ-022 MSUB/MSUBU SHALL compute {hi_out,lo_out} = {hi_in,lo_in} − product, modulo 2^64.
REQ-023 Division SHALL be restoring radix-2, one quotient bit per cycle, on operand magnitudes.
- lo_out = quotient, hi_out = remainder.
- Signed: quotient sign = a[31]^b[31]; remainder sign = a[31]; truncation toward zero.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo_out=0x80000000, hi_out=0.
REQ-025 Divisor = 0 (DIV or DIVU) SHALL give lo_out=0xFFFFFFFF, hi_out=src_a, with normal latency and no exception.
REQ-026 flush=1 SHALL force state→IDLE at the next edge, with no finish pulse for the aborted operation.
REQ-027 flush and start in the same cycle: flush SHALL win and the start SHALL be dropped.
REQ-028 flush during DONE SHALL suppress nothing; finish already asserted stands and the state returns to IDLE.
REQ-029 hi_out and lo_out SHALL hold their last values outside DONE.

Reset
REQ-030 With rst=1 at a rising edge, state SHALL become IDLE and all internal registers 0.
- finish=0, busy=0, hi_out=0, lo_out=0 from the next cycle.
REQ-031 Reset SHALL override start and flush.
REQ-032 Reset mid-operation SHALL abort with no finish pulse.

Configuration
REQ-033 Macro MULDIV_MADD_EN:
- Defined: ops 1xx SHALL accumulate per REQ-021/REQ-022.
- Undefined: op[2] SHALL be ignored; 100/110 behave as MULT and 101/111 as MULTU; hi_in/lo_in are unused and the accumulate adder is not synthesised.

Verification
REQ-034 The bench SHALL cover: MULT 0xFFFFFFFE×0x00000003 → finish at N+2, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
REQ-035 The bench SHALL cover: DIV 0xFFFFFFF9(−7)/0x00000002 → finish at N+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2.
REQ-036 The bench SHALL cover: DIVU 0x12345678/0 → lo=0xFFFFFFFF, hi=0x12345678 at N+33; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
REQ-037 The bench SHALL cover, with MULDIV_MADD_EN: hi_in=0, lo_in=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0; MSUB hi_in=lo_in=0, 1×1 → hi=lo=0xFFFFFFFF.
REQ-038 The bench SHALL cover: DIV started, flush at cycle N+10 → IDLE at N+11, no finish through N+40; new start at N+12 → result at N+45.
REQ-039 The bench SHALL cover: start held high continuously → operations accepted back-to-back, each producing exactly one finish pulse; rst at N+5 of a DIV → no finish, all outputs 0.
